bus_cycle_sequencer: RTL and testbench

- Generates the machine-cycle flags (fFetch, fMRead, fMWrite, fIORead, fIOWrite) and one-hot T-states (T1..T4, plus Tw) that drive pin_control and the rest of the bus datapath.
- Accepts one bus-cycle request at a time from the instruction sequencer.
- Inserts wait states from nwait and automatic I/O waits.
- Grants the external bus on busrq at cycle boundaries.

---
 rtl/bus_cycle_sequencer.sv | 135 +++++++++++++
 tb/tb_bus_cycle_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/bus_cycle_sequencer.sv
// rtl/bus_cycle_sequencer.sv - machine-cycle and T-state sequencer with wait insertion and bus grant
module bus_cycle_sequencer #(
  parameter int IO_AUTO_WAIT = 1,
  parameter int WAIT_LIMIT   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cyc_req,
  input  logic [2:0] cyc_type,
  input  logic       nwait,
  input  logic       busrq,
  output logic       cyc_ack,
  output logic       fFetch,
  output logic       fMRead,
  output logic       fMWrite,
  output logic       fIORead,
  output logic       fIOWrite,
  output logic       T1,
  output logic       T2,
  output logic       T3,
  output logic       T4,
  output logic       Tw,
  output logic       cyc_done,
  output logic       busack,
  output logic       wait_timeout
);

  localparam int WCW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [1:0]     AUTO_N  = IO_AUTO_WAIT[1:0];
  localparam logic [WCW-1:0] LIMIT_N = WCW'(WAIT_LIMIT);

  localparam logic [2:0] TY_FETCH  = 3'd0;
  localparam logic [2:0] TY_MREAD  = 3'd1;
  localparam logic [2:0] TY_MWRITE = 3'd2;
  localparam logic [2:0] TY_IOREAD = 3'd3;
  localparam logic [2:0] TY_IOWR   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE, ST_T1, ST_T2, ST_TW, ST_T3, ST_T4, ST_BUSACK
  } state_t;

  state_t         state, state_nxt;
  logic [2:0]     kind, kind_nxt;
  logic [1:0]     auto_cnt, auto_cnt_nxt;
  logic [WCW-1:0] wait_cnt, wait_cnt_nxt;

  logic is_io, is_mem, last_state, boundary, req_ok, limit_hit, active;
  logic ack_raw, timeout_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      kind     <= TY_FETCH;
      auto_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      kind     <= kind_nxt;
      auto_cnt <= auto_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    is_io      = (kind == TY_IOREAD) || (kind == TY_IOWR);
    is_mem     = (kind == TY_MREAD) || (kind == TY_MWRITE);
    // Memory read/write cycles end at T3; fetch and I/O cycles run on to T4.
    last_state = ((state == ST_T3) && is_mem) || (state == ST_T4);
    boundary   = (state == ST_IDLE) || last_state;
    req_ok     = cyc_req && (cyc_type <= TY_IOWR);
    limit_hit  = (WAIT_LIMIT > 0) && (wait_cnt == LIMIT_N);

    state_nxt    = state;
    kind_nxt     = kind;
    auto_cnt_nxt = auto_cnt;
    wait_cnt_nxt = wait_cnt;
    ack_raw      = 1'b0;
    timeout_raw  = 1'b0;

    if (boundary) begin
      if (busrq) begin
        state_nxt = ST_BUSACK;
      end else if (req_ok) begin
        state_nxt = ST_T1;
        kind_nxt  = cyc_type;
        ack_raw   = 1'b1;
      end else begin
        state_nxt = ST_IDLE;
      end
    end else begin
      unique case (state)
        ST_T1: begin
          state_nxt    = ST_T2;
          auto_cnt_nxt = '0;
          wait_cnt_nxt = '0;
        end
        ST_T2, ST_TW: begin
          // Automatic I/O waits come first and mask nwait; they never count toward the limit.
          if (is_io && (auto_cnt < AUTO_N)) begin
            state_nxt    = ST_TW;
            auto_cnt_nxt = auto_cnt + 2'd1;
          end else if (!nwait && !limit_hit) begin
            state_nxt    = ST_TW;
            wait_cnt_nxt = wait_cnt + 1'b1;
          end else begin
            state_nxt   = ST_T3;
            timeout_raw = !nwait && limit_hit;
          end
        end
        ST_T3:     state_nxt = ST_T4;
        ST_BUSACK: state_nxt = busrq ? ST_BUSACK : ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  assign active = (state == ST_T1) || (state == ST_T2) || (state == ST_TW) ||
                  (state == ST_T3) || (state == ST_T4);

  assign cyc_ack      = ack_raw && !reset;
  assign wait_timeout = timeout_raw && !reset;
  assign T1           = (state == ST_T1);
  assign T2           = (state == ST_T2);
  assign T3           = (state == ST_T3);
  assign T4           = (state == ST_T4);
  assign Tw           = (state == ST_TW);
  assign busack       = (state == ST_BUSACK);
  assign cyc_done     = last_state;
  assign fFetch       = active && (kind == TY_FETCH);
  assign fMRead       = active && (kind == TY_MREAD);
  assign fMWrite      = active && (kind == TY_MWRITE);
  assign fIORead      = active && (kind == TY_IOREAD);
  assign fIOWrite     = active && (kind == TY_IOWR);

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// tb/tb_bus_cycle_sequencer.sv - directed bench for bus_cycle_sequencer (IO_AUTO_WAIT=1, WAIT_LIMIT=4)
module tb_bus_cycle_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cyc_req = 1'b0;
  logic [2:0] cyc_type = 3'd0;
  logic       nwait = 1'b1;
  logic       busrq = 1'b0;
  logic cyc_ack, fFetch, fMRead, fMWrite, fIORead, fIOWrite;
  logic T1, T2, T3, T4, Tw, cyc_done, busack, wait_timeout;

  int errors = 0;
  int checks = 0;

  localparam logic [4:0] FN = 5'b00000, FF = 5'b10000, FR = 5'b01000, FW = 5'b00100,
                         FIR = 5'b00010, FIW = 5'b00001;
  localparam logic [4:0] SN = 5'b00000, S1 = 5'b10000, S2 = 5'b01000, S3 = 5'b00100,
                         S4 = 5'b00010, SW = 5'b00001;

  bus_cycle_sequencer #(.IO_AUTO_WAIT(1), .WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .cyc_req(cyc_req), .cyc_type(cyc_type),
    .nwait(nwait), .busrq(busrq), .cyc_ack(cyc_ack),
    .fFetch(fFetch), .fMRead(fMRead), .fMWrite(fMWrite),
    .fIORead(fIORead), .fIOWrite(fIOWrite),
    .T1(T1), .T2(T2), .T3(T3), .T4(T4), .Tw(Tw),
    .cyc_done(cyc_done), .busack(busack), .wait_timeout(wait_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic ack, input logic [4:0] fl,
                     input logic [4:0] ts, input logic done, input logic ba, input logic to);
    logic [13:0] obs, exp;
    obs = {cyc_ack, fFetch, fMRead, fMWrite, fIORead, fIOWrite, T1, T2, T3, T4, Tw,
           cyc_done, busack, wait_timeout};
    exp = {ack, fl, ts, done, ba, to};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (ack,flags5,T1234w,done,busack,timeout)",
             tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, then check settled outputs.
  task automatic step(input string tag, input logic req, input logic [2:0] typ,
                      input logic nw, input logic brq,
                      input logic ack, input logic [4:0] fl, input logic [4:0] ts,
                      input logic done, input logic ba, input logic to);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    cyc_req  = req;
    cyc_type = typ;
    nwait    = nw;
    busrq    = brq;
    #1;
    chk(tag, ack, fl, ts, done, ba, to);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("reset_idle", 0, FN, SN, 0, 0, 0);

    // Fetch, no waits
    step("f_c0_ack", 1, 3'd0, 1, 0, 1, FN, SN, 0, 0, 0);
    step("f_c1_t1",  0, 3'd0, 1, 0, 0, FF, S1, 0, 0, 0);
    step("f_c2_t2",  0, 3'd0, 1, 0, 0, FF, S2, 0, 0, 0);
    step("f_c3_t3",  0, 3'd0, 1, 0, 0, FF, S3, 0, 0, 0);
    step("f_c4_t4",  0, 3'd0, 1, 0, 0, FF, S4, 1, 0, 0);
    step("f_c5_idle",0, 3'd0, 1, 0, 0, FN, SN, 0, 0, 0);

    // Invalid type is never acked
    step("inv_c0",   1, 3'd5, 1, 0, 0, FN, SN, 0, 0, 0);
    step("inv_c1",   1, 3'd7, 1, 0, 0, FN, SN, 0, 0, 0);

    // MRead with two nwait waits
    step("mr_c0_ack",1, 3'd1, 1, 0, 1, FN, SN, 0, 0, 0);
    step("mr_c1_t1", 0, 3'd1, 0, 0, 0, FR, S1, 0, 0, 0);
    step("mr_c2_t2", 0, 3'd1, 0, 0, 0, FR, S2, 0, 0, 0);
    step("mr_c3_tw", 0, 3'd1, 0, 0, 0, FR, SW, 0, 0, 0);
    step("mr_c4_tw", 0, 3'd1, 1, 0, 0, FR, SW, 0, 0, 0);
    step("mr_c5_t3", 0, 3'd1, 1, 0, 0, FR, S3, 1, 0, 0);
    step("mr_c6_idle",0,3'd1, 1, 0, 0, FN, SN, 0, 0, 0);

    // I/O read, one automatic wait
    step("ior_c0",   1, 3'd3, 1, 0, 1, FN, SN, 0, 0, 0);
    step("ior_c1",   0, 3'd3, 1, 0, 0, FIR, S1, 0, 0, 0);
    step("ior_c2",   0, 3'd3, 1, 0, 0, FIR, S2, 0, 0, 0);
    step("ior_c3",   0, 3'd3, 1, 0, 0, FIR, SW, 0, 0, 0);
    step("ior_c4",   0, 3'd3, 1, 0, 0, FIR, S3, 0, 0, 0);
    step("ior_c5",   0, 3'd3, 1, 0, 0, FIR, S4, 1, 0, 0);
    step("ior_c6",   0, 3'd3, 1, 0, 0, FN, SN, 0, 0, 0);

    // I/O write, nwait low only while the automatic wait is decided
    step("iow_c0",   1, 3'd4, 1, 0, 1, FN, SN, 0, 0, 0);
    step("iow_c1",   0, 3'd4, 1, 0, 0, FIW, S1, 0, 0, 0);
    step("iow_c2",   0, 3'd4, 0, 0, 0, FIW, S2, 0, 0, 0);
    step("iow_c3",   0, 3'd4, 1, 0, 0, FIW, SW, 0, 0, 0);
    step("iow_c4",   0, 3'd4, 1, 0, 0, FIW, S3, 0, 0, 0);
    step("iow_c5",   0, 3'd4, 1, 0, 0, FIW, S4, 1, 0, 0);

    // Back-to-back: fetch then mwrite with no idle gap
    step("b2b_c0",   1, 3'd0, 1, 0, 1, FN, SN, 0, 0, 0);
    step("b2b_c1",   1, 3'd2, 1, 0, 0, FF, S1, 0, 0, 0);
    step("b2b_c2",   1, 3'd2, 1, 0, 0, FF, S2, 0, 0, 0);
    step("b2b_c3",   1, 3'd2, 1, 0, 0, FF, S3, 0, 0, 0);
    step("b2b_c4",   1, 3'd2, 1, 0, 1, FF, S4, 1, 0, 0);
    step("b2b_c5",   0, 3'd2, 1, 0, 0, FW, S1, 0, 0, 0);
    step("b2b_c6",   0, 3'd2, 1, 0, 0, FW, S2, 0, 0, 0);
    step("b2b_c7",   0, 3'd2, 1, 0, 0, FW, S3, 1, 0, 0);
    step("b2b_c8",   0, 3'd2, 1, 0, 0, FN, SN, 0, 0, 0);

    // Bus grant with a pending request
    step("bg_c0",    1, 3'd0, 1, 0, 1, FN, SN, 0, 0, 0);
    step("bg_c1",    1, 3'd1, 1, 0, 0, FF, S1, 0, 0, 0);
    step("bg_c2",    1, 3'd1, 1, 1, 0, FF, S2, 0, 0, 0);
    step("bg_c3",    1, 3'd1, 1, 1, 0, FF, S3, 0, 0, 0);
    step("bg_c4",    1, 3'd1, 1, 1, 0, FF, S4, 1, 0, 0);
    step("bg_c5",    1, 3'd1, 1, 1, 0, FN, SN, 0, 1, 0);
    step("bg_c6",    1, 3'd1, 1, 1, 0, FN, SN, 0, 1, 0);
    step("bg_c7",    1, 3'd1, 1, 0, 0, FN, SN, 0, 1, 0);
    step("bg_c8",    1, 3'd1, 1, 0, 1, FN, SN, 0, 0, 0);
    step("bg_c9",    0, 3'd1, 1, 0, 0, FR, S1, 0, 0, 0);
    step("bg_c10",   0, 3'd1, 1, 0, 0, FR, S2, 0, 0, 0);
    step("bg_c11",   0, 3'd1, 1, 0, 0, FR, S3, 1, 0, 0);

    // Wait limit of 4 with nwait stuck low
    step("to_c0",    1, 3'd1, 0, 0, 1, FN, SN, 0, 0, 0);
    step("to_c1",    0, 3'd1, 0, 0, 0, FR, S1, 0, 0, 0);
    step("to_c2",    0, 3'd1, 0, 0, 0, FR, S2, 0, 0, 0);
    step("to_c3",    0, 3'd1, 0, 0, 0, FR, SW, 0, 0, 0);
    step("to_c4",    0, 3'd1, 0, 0, 0, FR, SW, 0, 0, 0);
    step("to_c5",    0, 3'd1, 0, 0, 0, FR, SW, 0, 0, 0);
    step("to_c6",    0, 3'd1, 0, 0, 0, FR, SW, 0, 0, 1);
    step("to_c7",    0, 3'd1, 0, 0, 0, FR, S3, 1, 0, 0);
    step("to_c8",    0, 3'd1, 1, 0, 0, FN, SN, 0, 0, 0);

    // Reset in the middle of a wait state
    step("rs_c0",    1, 3'd2, 0, 0, 1, FN, SN, 0, 0, 0);
    step("rs_c1",    0, 3'd2, 0, 0, 0, FW, S1, 0, 0, 0);
    step("rs_c2",    0, 3'd2, 0, 0, 0, FW, S2, 0, 0, 0);
    step("rs_c3",    0, 3'd2, 0, 0, 0, FW, SW, 0, 0, 0);
    reset = 1'b1;
    step("rs_c4_idle",0,3'd2, 1, 0, 0, FN, SN, 0, 0, 0);
    step("rs_c5_ack",1, 3'd0, 1, 0, 1, FN, SN, 0, 0, 0);
    step("rs_c6_t1", 0, 3'd0, 1, 0, 0, FF, S1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
